// File: rtl/usb_uvc_pkg.sv
// Shared constants and types for the UVC payload sink.
// BFH bit positions, header length limits, parser states.
package usb_uvc_pkg;

    localparam int BFH_FID = 0;
    localparam int BFH_EOF = 1;
    localparam int BFH_ERR = 6;
    localparam int BFH_EOH = 7;

    localparam logic [7:0] HLE_MIN = 8'd2;
    localparam logic [7:0] HLE_MAX = 8'd12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_LEN,
        ST_HDR_BFH,
        ST_HDR_SKIP,
        ST_PAYLOAD,
        ST_DROP
    } pkt_state_t;

    function automatic logic [31:0] fsize(input logic [13:0] w,
                                          input logic [13:0] h);
        return {18'd0, w} * {18'd0, h} * 32'd2;
    endfunction

endpackage

// File: rtl/usb_uvc_hdr_parser.sv
// Packet FSM: strips the UVC payload header, strobes payload bytes,
// reports the packet's FID/EOF and header/stream errors.
module usb_uvc_hdr_parser
    import usb_uvc_pkg::*;
(
    input  logic       clk,
    input  logic       usb_rstn,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_sop,
    input  logic       in_eop,
    output logic       pay_stb,
    output logic       pay_first,
    output logic       bfh_stb,
    output logic       pkt_fid,
    output logic       pkt_eof,
    output logic       pkt_end,
    output logic       err_hdr,
    output logic       err_stream
);

    pkt_state_t state, state_d, st;
    logic [3:0] skip_cnt, skip_d;
    logic       fid_q, fid_d;
    logic       eof_q, eof_d;
    logic       first_q, first_d;

    always_ff @(posedge clk or negedge usb_rstn) begin
        if (!usb_rstn) begin
            state    <= ST_IDLE;
            skip_cnt <= 4'd0;
            fid_q    <= 1'b0;
            eof_q    <= 1'b0;
            first_q  <= 1'b0;
        end else begin
            state    <= state_d;
            skip_cnt <= skip_d;
            fid_q    <= fid_d;
            eof_q    <= eof_d;
            first_q  <= first_d;
        end
    end

    always_comb begin
        state_d    = state;
        skip_d     = skip_cnt;
        fid_d      = fid_q;
        eof_d      = eof_q;
        first_d    = first_q;
        pay_stb    = 1'b0;
        pay_first  = 1'b0;
        bfh_stb    = 1'b0;
        pkt_fid    = fid_q;
        pkt_eof    = eof_q;
        pkt_end    = 1'b0;
        err_hdr    = 1'b0;
        err_stream = 1'b0;
        st         = in_sop ? ST_HDR_LEN : state;
        if (in_valid) begin
            if (in_sop && (state == ST_HDR_BFH || state == ST_HDR_SKIP ||
                           state == ST_PAYLOAD))
                err_hdr = 1'b1;
            unique case (st)
                ST_HDR_LEN: begin
                    if (in_data < HLE_MIN || in_data > HLE_MAX) begin
                        err_hdr = 1'b1;
                        state_d = ST_DROP;
                    end else begin
                        skip_d  = 4'(in_data - HLE_MIN);
                        state_d = ST_HDR_BFH;
                    end
                end
                ST_HDR_BFH: begin
                    if (in_data[BFH_ERR]) begin
                        err_stream = 1'b1;
                        state_d    = ST_DROP;
                    end else begin
                        bfh_stb = 1'b1;
                        fid_d   = in_data[BFH_FID];
                        eof_d   = in_data[BFH_EOF];
                        pkt_fid = fid_d;
                        pkt_eof = eof_d;
                        first_d = 1'b1;
                        state_d = (skip_cnt != 4'd0) ? ST_HDR_SKIP : ST_PAYLOAD;
                    end
                end
                ST_HDR_SKIP: begin
                    skip_d = skip_cnt - 4'd1;
                    if (skip_cnt == 4'd1)
                        state_d = ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    pay_stb   = 1'b1;
                    pay_first = first_q;
                    first_d   = 1'b0;
                end
                ST_IDLE, ST_DROP: ;
                default: state_d = ST_IDLE;
            endcase
            if (in_eop) begin
                state_d = ST_IDLE;
                // only packets whose BFH was accepted carry framing info
                pkt_end = bfh_stb || st == ST_HDR_SKIP || st == ST_PAYLOAD;
            end
        end
    end

endmodule

// File: rtl/usb_uvc_payload_sink.sv
// UVC uncompressed payload sink: frame sync, byte counting and
// pixel coordinate tracking on top of the header parser.
module usb_uvc_payload_sink
    import usb_uvc_pkg::*;
#(
    parameter string       FRAME_TYPE = "MONO",
    parameter logic [13:0] FRAME_W    = 14'd640,
    parameter logic [13:0] FRAME_H    = 14'd360
) (
    input  logic        clk,
    input  logic        usb_rstn,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_sop,
    input  logic        in_eop,
    output logic        vf_sof,
    output logic        vf_valid,
    output logic [7:0]  vf_byte,
    output logic [13:0] vf_x,
    output logic [13:0] vf_y,
    output logic        vf_eof,
    output logic        err_hdr,
    output logic        err_stream,
    output logic        err_size
);

    localparam logic [31:0] FSIZE   = fsize(FRAME_W, FRAME_H);
    localparam bit          ALL_OUT = (FRAME_TYPE == "YUY2");

    logic pay_stb, pay_first, bfh_stb, pkt_fid, pkt_eof, pkt_end;
    logic p_err_hdr, p_err_stream;

    usb_uvc_hdr_parser u_parser (
        .clk       (clk),
        .usb_rstn  (usb_rstn),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_sop    (in_sop),
        .in_eop    (in_eop),
        .pay_stb   (pay_stb),
        .pay_first (pay_first),
        .bfh_stb   (bfh_stb),
        .pkt_fid   (pkt_fid),
        .pkt_eof   (pkt_eof),
        .pkt_end   (pkt_end),
        .err_hdr   (p_err_hdr),
        .err_stream(p_err_stream)
    );

    logic        synced, sync_n;
    logic        fid_seen, seen_n;
    logic        last_fid, lfid_n;
    logic        frame_open, open_n;
    logic        frame_fid, ffid_n;
    logic [31:0] bcnt, bcnt_n;
    logic [13:0] x_q, x_n, y_q, y_n;
    logic        ovf, ovf_n;
    logic        size_done, done_n;
    logic        start;
    logic        o_sof, o_valid, o_eof, o_err_size;
    logic [7:0]  o_byte;
    logic [13:0] o_x, o_y;

    always_comb begin
        sync_n     = synced;
        seen_n     = fid_seen;
        lfid_n     = last_fid;
        open_n     = frame_open;
        ffid_n     = frame_fid;
        bcnt_n     = bcnt;
        x_n        = x_q;
        y_n        = y_q;
        ovf_n      = ovf;
        done_n     = size_done;
        o_sof      = 1'b0;
        o_valid    = 1'b0;
        o_eof      = 1'b0;
        o_err_size = 1'b0;
        o_byte     = 8'd0;
        o_x        = 14'd0;
        o_y        = 14'd0;
        start      = pay_stb && pay_first && synced &&
                     (!frame_open || pkt_fid != frame_fid);

        if (bfh_stb) begin
            if (fid_seen && pkt_fid != last_fid)
                sync_n = 1'b1;
            lfid_n = pkt_fid;
            seen_n = 1'b1;
        end

        if (start) begin
            if (frame_open && bcnt != 32'd0 && bcnt != FSIZE && !size_done)
                o_err_size = 1'b1;
            open_n = 1'b1;
            ffid_n = pkt_fid;
            bcnt_n = 32'd0;
            x_n    = 14'd0;
            y_n    = 14'd0;
            ovf_n  = 1'b0;
            done_n = 1'b0;
        end

        if (pay_stb && open_n) begin
            if (bcnt_n < FSIZE) begin
                if (ALL_OUT || !bcnt_n[0]) begin
                    o_valid = 1'b1;
                    o_byte  = in_data;
                    o_x     = x_n;
                    o_y     = y_n;
                    o_sof   = (bcnt_n == 32'd0);
                end
                o_eof = (bcnt_n == FSIZE - 32'd1);
                // pixel advances after the second byte of each pair
                if (bcnt_n[0]) begin
                    if (x_n == FRAME_W - 14'd1) begin
                        x_n = 14'd0;
                        y_n = (y_n == FRAME_H - 14'd1) ? 14'd0 : y_n + 14'd1;
                    end else begin
                        x_n = x_n + 14'd1;
                    end
                end
                bcnt_n = bcnt_n + 32'd1;
            end else begin
                ovf_n = 1'b1;
            end
        end

        if (pkt_end && pkt_eof) begin
            sync_n = 1'b1;
            if (open_n) begin
                if ((bcnt_n != FSIZE || ovf_n) && !done_n)
                    o_err_size = 1'b1;
                open_n = 1'b0;
                ovf_n  = 1'b0;
            end
        end
        if (o_err_size)
            done_n = 1'b1;
    end

    always_ff @(posedge clk or negedge usb_rstn) begin
        if (!usb_rstn) begin
            synced     <= 1'b0;
            fid_seen   <= 1'b0;
            last_fid   <= 1'b0;
            frame_open <= 1'b0;
            frame_fid  <= 1'b0;
            bcnt       <= 32'd0;
            x_q        <= 14'd0;
            y_q        <= 14'd0;
            ovf        <= 1'b0;
            size_done  <= 1'b0;
            vf_sof     <= 1'b0;
            vf_valid   <= 1'b0;
            vf_byte    <= 8'd0;
            vf_x       <= 14'd0;
            vf_y       <= 14'd0;
            vf_eof     <= 1'b0;
            err_hdr    <= 1'b0;
            err_stream <= 1'b0;
            err_size   <= 1'b0;
        end else begin
            synced     <= sync_n;
            fid_seen   <= seen_n;
            last_fid   <= lfid_n;
            frame_open <= open_n;
            frame_fid  <= ffid_n;
            bcnt       <= bcnt_n;
            x_q        <= x_n;
            y_q        <= y_n;
            ovf        <= ovf_n;
            size_done  <= done_n;
            vf_sof     <= o_sof;
            vf_valid   <= o_valid;
            vf_byte    <= o_byte;
            vf_x       <= o_x;
            vf_y       <= o_y;
            vf_eof     <= o_eof;
            err_hdr    <= p_err_hdr;
            err_stream <= p_err_stream;
            err_size   <= o_err_size;
        end
    end

endmodule
